// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_BUS     = 32;
    localparam int unsigned DATA_BUS     = 32;
    localparam int unsigned WIDTH_W      = 4;
    localparam int unsigned RD_LAT_DEF   = 1;
    localparam int unsigned LOCK_MAX_DEF = 4;
    localparam int unsigned LAT_CNT_W    = 3;
    localparam int unsigned LOCK_CNT_W   = 4;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick with an optional sticky lock owner.
module rr_pick2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic ptr_i,
    input  logic lock_owner_i,
    input  logic lock_valid_i,
    input  logic lock_expired_i,
    output logic grant_valid_o,
    output logic grant_idx_o
);

    logic lock_req;
    logic other_req;

    assign lock_req  = lock_owner_i ? req1_i : req0_i;
    assign other_req = lock_owner_i ? req0_i : req1_i;

    always_comb begin
        grant_valid_o = req0_i | req1_i;
        grant_idx_o   = 1'b0;
        if (lock_valid_i && lock_req) begin
            // An expired lock yields only if the other side is actually waiting.
            grant_idx_o = (other_req && lock_expired_i) ? ~lock_owner_i : lock_owner_i;
        end else if (req0_i && req1_i) begin
            grant_idx_o = ptr_i;
        end else begin
            grant_idx_o = req1_i;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single mem port between the executor (rq0) and the packet loader (rq1).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_BUS,
    parameter int unsigned DATA_W   = DATA_BUS,
    parameter int unsigned RD_LAT   = RD_LAT_DEF,
    parameter int unsigned LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rq0_req_i,
    input  logic               rq0_we_i,
    input  logic [ADDR_W-1:0]  rq0_addr_i,
    input  logic [WIDTH_W-1:0] rq0_width_i,
    input  logic [DATA_W-1:0]  rq0_data_i,
    input  logic               rq0_lock_i,
    output logic               rq0_ack_o,
    output logic [DATA_W-1:0]  rq0_data_o,
    input  logic               rq1_req_i,
    input  logic               rq1_we_i,
    input  logic [ADDR_W-1:0]  rq1_addr_i,
    input  logic [WIDTH_W-1:0] rq1_width_i,
    input  logic [DATA_W-1:0]  rq1_data_i,
    input  logic               rq1_lock_i,
    output logic               rq1_ack_o,
    output logic [DATA_W-1:0]  rq1_data_o,
    output logic               mem_ce_o,
    output logic               mem_we_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic [WIDTH_W-1:0] mem_width_o,
    output logic [DATA_W-1:0]  mem_data_o,
    input  logic [DATA_W-1:0]  mem_data_i,
    output logic               busy_o,
    output logic               owner_o
);

    arb_state_e            state_q;
    logic [LAT_CNT_W-1:0]  lat_q;
    logic [LOCK_CNT_W-1:0] lock_cnt_q;
    logic                  ptr_q;
    logic                  lock_valid_q;

    logic                  grant_valid;
    logic                  grant_idx;
    logic                  lock_expired;
    logic                  other_waiting;
    logic                  owner_lock;
    logic                  sel_we;
    logic [ADDR_W-1:0]     sel_addr;
    logic [WIDTH_W-1:0]    sel_width;
    logic [DATA_W-1:0]     sel_data;

    assign sel_we        = grant_idx ? rq1_we_i    : rq0_we_i;
    assign sel_addr      = grant_idx ? rq1_addr_i  : rq0_addr_i;
    assign sel_width     = grant_idx ? rq1_width_i : rq0_width_i;
    assign sel_data      = grant_idx ? rq1_data_i  : rq0_data_i;
    assign other_waiting = grant_idx ? rq0_req_i   : rq1_req_i;
    assign owner_lock    = owner_o   ? rq1_lock_i  : rq0_lock_i;
    assign lock_expired  = lock_cnt_q >= LOCK_CNT_W'(LOCK_MAX);
    assign busy_o        = (state_q != ARB_IDLE);

    rr_pick2 u_pick (
        .req0_i         (rq0_req_i),
        .req1_i         (rq1_req_i),
        .ptr_i          (ptr_q),
        .lock_owner_i   (owner_o),
        .lock_valid_i   (lock_valid_q),
        .lock_expired_i (lock_expired),
        .grant_valid_o  (grant_valid),
        .grant_idx_o    (grant_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ARB_IDLE;
            lat_q        <= '0;
            lock_cnt_q   <= '0;
            ptr_q        <= 1'b0;
            lock_valid_q <= 1'b0;
            owner_o      <= 1'b0;
            mem_ce_o     <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_width_o  <= '0;
            mem_data_o   <= '0;
            rq0_ack_o    <= 1'b0;
            rq1_ack_o    <= 1'b0;
            rq0_data_o   <= '0;
            rq1_data_o   <= '0;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (grant_valid) begin
                        owner_o     <= grant_idx;
                        mem_ce_o    <= 1'b1;
                        mem_we_o    <= sel_we;
                        mem_addr_o  <= sel_addr;
                        mem_width_o <= sel_width;
                        mem_data_o  <= sel_data;
                        lat_q       <= sel_we ? '0 : LAT_CNT_W'(RD_LAT);
                        // Counts consecutive grants to one owner while the other side waits.
                        if (grant_idx != owner_o) begin
                            lock_cnt_q <= other_waiting ? LOCK_CNT_W'(1) : '0;
                        end else if (other_waiting) begin
                            lock_cnt_q <= lock_cnt_q + LOCK_CNT_W'(1);
                        end
                        state_q <= ARB_ACCESS;
                    end
                end
                ARB_ACCESS: begin
                    if (lat_q == '0) begin
                        mem_ce_o <= 1'b0;
                        if (owner_o) begin
                            rq1_ack_o <= 1'b1;
                            if (!mem_we_o) rq1_data_o <= mem_data_i;
                        end else begin
                            rq0_ack_o <= 1'b1;
                            if (!mem_we_o) rq0_data_o <= mem_data_i;
                        end
                        state_q <= ARB_DONE;
                    end else begin
                        lat_q <= lat_q - LAT_CNT_W'(1);
                    end
                end
                ARB_DONE: begin
                    rq0_ack_o    <= 1'b0;
                    rq1_ack_o    <= 1'b0;
                    lock_valid_q <= owner_lock;
                    if (!owner_lock) begin
                        ptr_q      <= ~owner_o;
                        lock_cnt_q <= '0;
                    end
                    state_q <= ARB_IDLE;
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a one-cycle-latency SRAM model.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned RD_LAT   = 1;
    localparam int unsigned LOCK_MAX = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              rq0_req_i, rq0_we_i, rq0_lock_i, rq0_ack_o;
    logic [ADDR_W-1:0] rq0_addr_i;
    logic [3:0]        rq0_width_i;
    logic [DATA_W-1:0] rq0_data_i, rq0_data_o;
    logic              rq1_req_i, rq1_we_i, rq1_lock_i, rq1_ack_o;
    logic [ADDR_W-1:0] rq1_addr_i;
    logic [3:0]        rq1_width_i;
    logic [DATA_W-1:0] rq1_data_i, rq1_data_o;
    logic              mem_ce_o, mem_we_o, busy_o, owner_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [3:0]        mem_width_o;
    logic [DATA_W-1:0] mem_data_o, mem_data_i;

    logic [31:0] sram [256];
    logic [31:0] rd_q;
    logic        sram_init;

    int n_chk = 0;
    int n_bad = 0;
    int seq [16];
    int exp3 [4]  = '{0, 1, 0, 1};
    int exp4 [11] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RD_LAT   (RD_LAT),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rq0_req_i   (rq0_req_i),
        .rq0_we_i    (rq0_we_i),
        .rq0_addr_i  (rq0_addr_i),
        .rq0_width_i (rq0_width_i),
        .rq0_data_i  (rq0_data_i),
        .rq0_lock_i  (rq0_lock_i),
        .rq0_ack_o   (rq0_ack_o),
        .rq0_data_o  (rq0_data_o),
        .rq1_req_i   (rq1_req_i),
        .rq1_we_i    (rq1_we_i),
        .rq1_addr_i  (rq1_addr_i),
        .rq1_width_i (rq1_width_i),
        .rq1_data_i  (rq1_data_i),
        .rq1_lock_i  (rq1_lock_i),
        .rq1_ack_o   (rq1_ack_o),
        .rq1_data_o  (rq1_data_o),
        .mem_ce_o    (mem_ce_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_width_o (mem_width_o),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_data_i),
        .busy_o      (busy_o),
        .owner_o     (owner_o)
    );

    // SRAM word i powers up as 0xC0DE0000 | i; read data lags the address by one cycle.
    always @(posedge clk) begin
        if (sram_init) begin
            for (int i = 0; i < 256; i++) sram[i] <= 32'hC0DE_0000 | 32'(i);
        end else if (mem_ce_o && mem_we_o) begin
            sram[mem_addr_o[9:2]] <= mem_data_o;
        end
        rd_q <= sram[mem_addr_o[9:2]];
    end
    assign mem_data_i = rd_q;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int who, input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] data, input logic lock);
        if (who == 0) begin
            rq0_req_i = req; rq0_we_i = we; rq0_addr_i = addr;
            rq0_data_i = data; rq0_lock_i = lock; rq0_width_i = 4'hF;
        end else begin
            rq1_req_i = req; rq1_we_i = we; rq1_addr_i = addr;
            rq1_data_i = data; rq1_lock_i = lock; rq1_width_i = 4'hF;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Starts at an IDLE-cycle negedge; returns ack latency in cycles (-1 on timeout).
    task automatic access(input int who, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output logic [31:0] rdata);
        lat   = -1;
        rdata = 32'h0;
        drive(who, 1'b1, we, addr, wdata, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if ((who == 0) ? rq0_ack_o : rq1_ack_o) begin
                lat   = k;
                rdata = (who == 0) ? rq0_data_o : rq1_data_o;
                break;
            end
        end
        drive(who, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
    endtask

    task automatic collect(input int n, input int rq1_limit, input int budget);
        int got = 0;
        int n1  = 0;
        for (int i = 0; i < 16; i++) seq[i] = 9;
        for (int k = 0; k < budget && got < n; k++) begin
            @(negedge clk);
            if (rq0_ack_o && rq1_ack_o) check_eq("dual_ack", 32'd1, 32'd0);
            if (rq0_ack_o || rq1_ack_o) begin
                seq[got] = rq1_ack_o ? 1 : 0;
                check_eq("owner_at_ack", 32'(owner_o), 32'(rq1_ack_o));
                got++;
                if (rq1_ack_o) begin
                    n1++;
                    if (n1 == rq1_limit) rq1_req_i = 1'b0;
                end
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          lat;
        int          t0, t1, acks, ces;
        logic [31:0] rdata;

        // Reset state and single read with RD_LAT = 1.
        sram_init = 1'b1;
        rst       = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        sram_init = 1'b0;
        check_eq("rst_ce", 32'(mem_ce_o), 32'd0);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_owner", 32'(owner_o), 32'd0);
        check_eq("rst_ack", 32'({rq1_ack_o, rq0_ack_o}), 32'd0);
        check_eq("rst_data0", rq0_data_o, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'd64, 32'h0, 1'b0);
        @(negedge clk);
        check_eq("t1_c1_ce", 32'(mem_ce_o), 32'd1);
        check_eq("t1_c1_addr", mem_addr_o, 32'd64);
        check_eq("t1_c1_ack", 32'(rq0_ack_o), 32'd0);
        @(negedge clk);
        check_eq("t1_c2_ce", 32'(mem_ce_o), 32'd1);
        check_eq("t1_c2_ack", 32'(rq0_ack_o), 32'd0);
        @(negedge clk);
        check_eq("t1_c3_ce", 32'(mem_ce_o), 32'd0);
        check_eq("t1_c3_ack", 32'(rq0_ack_o), 32'd1);
        check_eq("t1_rdata", rq0_data_o, 32'hC0DE_0010);
        check_eq("t1_other_data", rq1_data_o, 32'd0);
        check_eq("t1_other_ack", 32'(rq1_ack_o), 32'd0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        check_eq("t1_c4_ack", 32'(rq0_ack_o), 32'd0);
        check_eq("t1_c4_busy", 32'(busy_o), 32'd0);

        // Simultaneous writes from reset: rq0 first.
        apply_reset();
        t0 = -1;
        t1 = -1;
        drive(0, 1'b1, 1'b1, 32'h10, 32'hAAAA_5555, 1'b0);
        drive(1, 1'b1, 1'b1, 32'h20, 32'h1234_5678, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (rq0_ack_o && rq1_ack_o) check_eq("t2_dual_ack", 32'd1, 32'd0);
            if (rq0_ack_o) begin t0 = k; rq0_req_i = 1'b0; end
            if (rq1_ack_o) begin t1 = k; rq1_req_i = 1'b0; end
        end
        check_eq("t2_ack0_cycle", 32'(t0), 32'd2);
        check_eq("t2_ack1_cycle", 32'(t1), 32'd5);
        access(0, 1'b0, 32'h10, 32'h0, lat, rdata);
        check_eq("t2_rb0_lat", 32'(lat), 32'd3);
        check_eq("t2_rb0_data", rdata, 32'hAAAA_5555);
        access(1, 1'b0, 32'h20, 32'h0, lat, rdata);
        check_eq("t2_rb1_lat", 32'(lat), 32'd3);
        check_eq("t2_rb1_data", rdata, 32'h1234_5678);

        // Continuous requests, no lock: strict alternation.
        apply_reset();
        drive(0, 1'b1, 1'b1, 32'h100, 32'h1, 1'b0);
        drive(1, 1'b1, 1'b1, 32'h104, 32'h2, 1'b0);
        collect(4, 0, 40);
        for (int i = 0; i < 4; i++) check_eq("t3_grant_seq", 32'(seq[i]), 32'(exp3[i]));

        // rq1 locked for 8 writes while rq0 keeps asking: lock yields after LOCK_MAX grants.
        apply_reset();
        drive(0, 1'b1, 1'b1, 32'h108, 32'h3, 1'b0);
        drive(1, 1'b1, 1'b1, 32'h10C, 32'h4, 1'b1);
        collect(11, 8, 80);
        for (int i = 0; i < 11; i++) check_eq("t4_grant_seq", 32'(seq[i]), 32'(exp4[i]));

        // Reset during a read access aborts it.
        apply_reset();
        drive(0, 1'b1, 1'b0, 32'd64, 32'h0, 1'b0);
        @(negedge clk);
        check_eq("t5_ce_before", 32'(mem_ce_o), 32'd1);
        rst = 1'b0;
        #1;
        check_eq("t5_ce_abort", 32'(mem_ce_o), 32'd0);
        check_eq("t5_busy_abort", 32'(busy_o), 32'd0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        acks = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (rq0_ack_o || rq1_ack_o) acks++;
        end
        check_eq("t5_no_ack", 32'(acks), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        access(0, 1'b0, 32'd68, 32'h0, lat, rdata);
        check_eq("t5_reissue_lat", 32'(lat), 32'd3);
        check_eq("t5_reissue_data", rdata, 32'hC0DE_0011);

        // rq0 drops req mid-access: completes once, nothing more.
        drive(0, 1'b1, 1'b0, 32'd72, 32'h0, 1'b0);
        @(negedge clk);
        ces = mem_ce_o ? 1 : 0;
        rq0_req_i = 1'b0;
        acks = 0;
        t0   = -1;
        for (int k = 2; k <= 9; k++) begin
            @(negedge clk);
            if (mem_ce_o) ces++;
            if (rq0_ack_o) begin acks++; t0 = k; end
        end
        check_eq("t6_ack_count", 32'(acks), 32'd1);
        check_eq("t6_ack_cycle", 32'(t0), 32'd3);
        check_eq("t6_ce_cycles", 32'(ces), 32'd2);
        check_eq("t6_rdata", rq0_data_o, 32'hC0DE_0012);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single mem port (mem -> sram path) between two requesters: requester 0 is the executor, requester 1 is the packet loader that writes incoming packets into SRAM.
- Round-robin arbitration with an optional bounded lock for back-to-back bursts.
- Latches each command, sequences the mem access, including read latency, and returns a one-cycle ack with read data.
- Sits between the requesters and mem; mem and sram are unchanged.

Parameters:
- ADDR_W, 32, address width; matches `ADDR_BUS.
- DATA_W, 32, data width; matches `DATA_BUS.
- RD_LAT, 1, cycles from mem_ce_o/address presented until mem_data_i is valid. Range 0..7.
- LOCK_MAX, 4, maximum consecutive grants to one locked owner while the other requester is waiting. Range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- rqN_req_i  in  1  access request (N = 0, 1; the same port set exists for each requester).
- rqN_we_i  in  1  1 = write, 0 = read.
- rqN_addr_i  in  ADDR_W  byte address.
- rqN_width_i  in  4  access width, passed through to mem.
- rqN_data_i  in  DATA_W  write data.
- rqN_lock_i  in  1  keep the grant after this access.
- rqN_ack_o  out  1  one-cycle completion pulse.
- rqN_data_o  out  DATA_W  read data; valid with ack, held until the next ack to the same requester.
- mem_ce_o  out  1  mem chip enable.
- mem_we_o  out  1  mem write enable.
- mem_addr_o  out  ADDR_W  mem address.
- mem_width_o  out  4  mem access width.
- mem_data_o  out  DATA_W  mem write data.
- mem_data_i  in  DATA_W  mem read data.
- busy_o  out  1  arbiter state is not IDLE.
- owner_o  out  1  index of the current or most recent grantee.

Behaviour:
- Reset (rst = 0, asynchronous):
  - All outputs go to 0 and the FSM goes to IDLE.
  - Priority pointer = 0 (requester 0 preferred), lock counter = 0.
  - An in-flight access is aborted: no ack is issued and mem_ce_o drops immediately.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No req: stay in IDLE; mem_ce_o = 0.
  - One req: grant that requester.
  - Both req: grant the requester indicated by the pointer, unless the lock rule applies.
  - On grant: latch we/addr/width/data into command registers, set owner_o, go to ACCESS.
- ACCESS:
  - mem_ce_o = 1; mem_we/addr/width/data driven from the latched registers, stable throughout.
  - Write: exactly 1 cycle, then DONE.
  - Read: 1 + RD_LAT cycles, counted by a down-counter. mem_data_i is captured into the owner's rdata register at the final ACCESS edge, then DONE.
- DONE:
  - mem_ce_o = 0; rq[owner]_ack_o = 1 for this cycle only; requests are not sampled.
  - Next state is IDLE.
- End-to-end latency, from req sampled in IDLE at edge 0: ack appears in cycle 2 for a write, cycle 2 + RD_LAT for a read.
- Requester rules:
  - Hold req and the command stable until ack.
  - Drop or change req at the edge that ends the ack cycle; a request still high in the following IDLE is a new access.
  - Dropping req mid-ACCESS does not cancel the access; it completes and acks.
- Pointer update:
  - After each DONE without an effective lock, the pointer = the other requester.
  - With an effective lock, the pointer is unchanged.
- Lock rule, evaluated in IDLE:
  - If the previous owner had lock_i = 1 in DONE and its req is high now, the previous owner wins over the pointer.
  - Exception: the other requester is requesting and the lock counter has reached LOCK_MAX. The other requester then wins, and the counter clears.
  - The lock counter increments on each lock-won grant while the other requester is waiting, and clears when the owner changes or the lock is released.
  - A lock with the owner's req low is ignored.
- Simultaneous first requests after reset: requester 0 wins.
- The ack is never asserted to both requesters in the same cycle.
- The read-data register of the non-owner is untouched.

Decomposition:
- Shared package / def.vh holds:
  - state encodings ARB_IDLE/ARB_ACCESS/ARB_DONE;
  - `ADDR_BUS/`DATA_BUS;
  - a width constant for the 4-bit access width;
  - RD_LAT and LOCK_MAX default constants.
- One sub-module, rr_pick2: combinational 2-way round-robin pick from (req0, req1, pointer, lock_owner, lock_valid, lock_expired) -> (grant_valid, grant_idx).
- The FSM, latches and counters stay in mem_arbiter.

Test Plan:
1. Reset released, rq0 reads addr 64, RD_LAT = 1 -> mem_ce_o high for 2 cycles with mem_addr_o = 64; rq0_ack_o pulses at cycle 3; rq0_data_o = SRAM word at 64.
2. rq0 and rq1 both write from reset (rq0 addr 0x10 data 0xAAAA5555, rq1 addr 0x20 data 0x12345678) -> rq0 is granted first and acks in cycle 2; rq1 acks in cycle 5; both words read back correctly.
3. Both requesters continuously requesting, no lock -> grants alternate 0,1,0,1; owner_o toggles on every grant.
4. rq1 with lock = 1 issuing 8 writes while rq0 is requesting, LOCK_MAX = 4 -> rq1 gets 4 consecutive grants, then rq0 gets 1, then rq1 resumes.
5. rst driven low during read ACCESS -> mem_ce_o falls the same cycle, no ack; after release, a re-issued read completes normally.
6. rq0 drops req mid-ACCESS -> the access still completes and rq0_ack_o pulses once; no second access is issued.
